// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, WIDTH iterations plus a sign-fix cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [2:0]       mdop,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_orig;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_is_div;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic             r_dz;
    logic             r_busy;
    logic             r_done;
    logic             r_divzero;

    logic               w_launch;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [WIDTH-1:0]   w_iter_hi;
    logic [WIDTH-1:0]   w_iter_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_launch = (r_state == S_IDLE) && start && (mdop[2] == 1'b0);
    assign w_a_neg  = mdop[0] & data1[WIDTH-1];
    assign w_b_neg  = mdop[0] & data2[WIDTH-1];
    assign w_abs_a  = w_a_neg ? (~data1 + WIDTH'(1)) : data1;
    assign w_abs_b  = w_b_neg ? (~data2 + WIDTH'(1)) : data2;

    // Multiply keeps the multiplier in acc_lo; divide keeps the dividend there and the remainder in acc_hi.
    assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};

    assign w_prod = r_neg_res ? (~{r_acc_hi, r_acc_lo} + (2*WIDTH)'(1)) : {r_acc_hi, r_acc_lo};
    assign w_quo  = r_neg_res ? (~r_acc_lo + WIDTH'(1)) : r_acc_lo;
    assign w_rem  = r_neg_rem ? (~r_acc_hi + WIDTH'(1)) : r_acc_hi;

    // One multiply or divide iteration.
    always_comb begin
        w_iter_hi = r_acc_hi;
        w_iter_lo = r_acc_lo;
        if (r_is_div) begin
            if (w_div_diff[WIDTH] == 1'b0) begin
                w_iter_hi = w_div_diff[WIDTH-1:0];
                w_iter_lo = {r_acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_iter_hi = w_div_shift[WIDTH-1:0];
                w_iter_lo = {r_acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_iter_hi = w_mul_sum[WIDTH:1];
            w_iter_lo = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_launch ? S_RUN : S_IDLE;
            S_RUN:   w_next = (r_cnt == CW'(WIDTH - 1)) ? S_FIX : S_RUN;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath, HI/LO and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_opb     <= '0;
            r_orig    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_cnt     <= '0;
                        r_acc_hi  <= '0;
                        r_acc_lo  <= mdop[1] ? w_abs_a : w_abs_b;
                        r_opb     <= mdop[1] ? w_abs_b : w_abs_a;
                        r_orig    <= data1;
                        r_is_div  <= mdop[1];
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_dz      <= mdop[1] && (data2 == {WIDTH{1'b0}});
                        r_busy    <= 1'b1;
                    end else if (start && (mdop == 3'b100)) begin
                        r_hi <= data1;
                    end else if (start && (mdop == 3'b101)) begin
                        r_lo <= data1;
                    end
                end
                S_RUN: begin
                    r_acc_hi <= w_iter_hi;
                    r_acc_lo <= w_iter_lo;
                    r_cnt    <= r_cnt + CW'(1);
                end
                S_FIX: begin
                    if (r_dz) begin
                        r_hi <= r_orig;
                        r_lo <= {WIDTH{1'b1}};
                    end else if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_divzero <= r_dz;
                    r_cnt     <= '0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign divzero = r_divzero;
    assign hi      = r_hi;
    assign lo      = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus queues expectations, a negedge monitor checks them.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [2:0]  mdop;
    logic        start;
    logic        busy;
    logic        done;
    logic        divzero;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    // mask bits: 0 hi, 1 lo, 2 busy, 3 done, 4 divzero, 5 scoreboard drained
    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        busy;
        logic        done;
        logic        dz;
        logic [5:0]  mask;
    } probe_t;

    exp_t   sb[$];
    probe_t pq[$];
    int     n_checks = 0;
    int     n_fails  = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .data1   (data1),
        .data2   (data2),
        .mdop    (mdop),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .divzero (divzero),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Monitor: pops the scoreboard on done and evaluates queued probes.
    initial begin : monitor
        int     busy_len;
        logic   prev_done;
        exp_t   e;
        probe_t p;
        busy_len  = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) busy_len = 0;
            else if (busy) busy_len++;
            if (done) begin
                chk("done_single_pulse", 64'(prev_done), 64'(0));
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_done: got done with empty scoreboard, hi=%h lo=%h", hi, lo);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, ".hi"}, 64'(hi), 64'(e.hi));
                    chk({e.name, ".lo"}, 64'(lo), 64'(e.lo));
                    chk({e.name, ".divzero"}, 64'(divzero), 64'(e.dz));
                    chk({e.name, ".busy_cycles"}, 64'(busy_len), 64'(33));
                end
                busy_len = 0;
            end
            prev_done = done;
            while (pq.size() > 0) begin
                p = pq.pop_front();
                if (p.mask[0]) chk({p.name, ".hi"}, 64'(hi), 64'(p.hi));
                if (p.mask[1]) chk({p.name, ".lo"}, 64'(lo), 64'(p.lo));
                if (p.mask[2]) chk({p.name, ".busy"}, 64'(busy), 64'(p.busy));
                if (p.mask[3]) chk({p.name, ".done"}, 64'(done), 64'(p.done));
                if (p.mask[4]) chk({p.name, ".divzero"}, 64'(divzero), 64'(p.dz));
                if (p.mask[5]) chk({p.name, ".pending"}, 64'(sb.size()), 64'(0));
            end
        end
    end

    task automatic probe(input string nm, input logic [31:0] h, input logic [31:0] l,
                         input logic b, input logic d, input logic z, input logic [5:0] m);
        probe_t p;
        p.name = nm; p.hi = h; p.lo = l; p.busy = b; p.done = d; p.dz = z; p.mask = m;
        pq.push_back(p);
    endtask

    task automatic expect_result(input string nm, input logic [31:0] h, input logic [31:0] l, input logic z);
        exp_t e;
        e.name = nm; e.hi = h; e.lo = l; e.dz = z;
        sb.push_back(e);
    endtask

    // Entered at posedge+1 with an op launched; leaves one cycle after busy falls.
    task automatic wait_idle(input string nm);
        for (int n = 0; n < 60 && busy; n++) begin
            @(posedge clk); #1;
        end
        probe({nm, ".idle"}, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'h04);
        @(posedge clk); #1;
    endtask

    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic ez);
        expect_result(nm, eh, el, ez);
        start = 1'b1; mdop = op; data1 = a; data2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(nm);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst = 1'b1; start = 1'b0; mdop = 3'b000; data1 = 32'h0; data2 = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        probe("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'h1F);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("multu_7x6",   3'b000, 32'd7,        32'd6,        32'h00000000, 32'h0000002A, 1'b0);
        run_op("mult_m3x5",   3'b001, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run_op("multu_max",   3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("divu_100_7",  3'b010, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
        run_op("div_m7_2",    3'b011, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("div_ovf",     3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_op("divu_5_0",    3'b010, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1);
        run_op("div_m8_0",    3'b011, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1);
        run_op("multu_2x2",   3'b000, 32'd2,        32'd2,        32'h00000000, 32'h00000004, 1'b0);

        // MTHI then MTLO back to back, then a NOP opcode
        start = 1'b1; mdop = 3'b100; data1 = 32'hDEADBEEF;
        @(posedge clk); #1;
        probe("mthi", 32'hDEADBEEF, 32'h00000004, 1'b0, 1'b0, 1'b0, 6'h1F);
        mdop = 3'b101; data1 = 32'h12345678;
        @(posedge clk); #1;
        probe("mtlo", 32'hDEADBEEF, 32'h12345678, 1'b0, 1'b0, 1'b0, 6'h1F);
        mdop = 3'b110; data1 = 32'hAAAA5555;
        @(posedge clk); #1;
        probe("nop", 32'hDEADBEEF, 32'h12345678, 1'b0, 1'b0, 1'b0, 6'h1F);
        start = 1'b0;
        @(posedge clk); #1;

        // restart attempts and operand churn while busy
        expect_result("mid_op_multu_3x4", 32'h0, 32'd12, 1'b0);
        start = 1'b1; mdop = 3'b000; data1 = 32'd3; data2 = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        start = 1'b1; mdop = 3'b010; data1 = 32'd99; data2 = 32'd1;
        repeat (3) begin @(posedge clk); #1; end
        probe("run_hold", 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0, 1'b0, 6'h1F);
        start = 1'b0; data1 = 32'h55; data2 = 32'd7;
        wait_idle("mid_op_multu_3x4");

        // asynchronous reset in the middle of a divide
        start = 1'b1; mdop = 3'b010; data1 = 32'd50; data2 = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        probe("abort", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'h1F);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op("divu_9_3",    3'b010, 32'd9,        32'd3,        32'h00000000, 32'h00000003, 1'b0);

        probe("final", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'h20);
        @(posedge clk); #1;
        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
